// File: rtl/stopwatch_timer.sv
// MM:SS BCD stopwatch / countdown timer with run/pause control, lap freeze,
// preload and a done flag. Counting ticks come from an internal prescaler on clk_i.
module stopwatch_timer #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int FAST_FACTOR = 4,
    parameter int DIV_W       = 27
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        speed_up_i,
    input  logic        start_stop_i,
    input  logic        clear_i,
    input  logic        lap_i,
    input  logic        mode_i,
    input  logic        load_i,
    input  logic [15:0] load_bcd_i,
    output logic [3:0]  digit0_o,
    output logic [3:0]  digit1_o,
    output logic [3:0]  digit2_o,
    output logic [3:0]  digit3_o,
    output logic        running_o,
    output logic        lap_active_o,
    output logic        done_o,
    output logic        tick_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [DIV_W-1:0] LIMIT_SLOW = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] LIMIT_FAST = DIV_W'(TICK_DIV / FAST_FACTOR - 1);

    logic [1:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic             speed_q;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [15:0]      count_q, count_d;
    logic [15:0]      disp_q, disp_d;
    logic             lap_q, lap_d;
    logic [DIV_W-1:0] limit;
    logic             tick;
    logic [15:0]      count_dec;

    // Digit layout in all 16-bit words: {M10, M1, S10, S1}.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd5) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (v[11:8] != 4'd9) begin
                    r[11:8] = v[11:8] + 4'd1;
                end else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = (v[15:12] == 4'd9) ? 4'd0 : v[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Only called with a non-zero value, so M10 never underflows.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (v[11:8] != 4'd0) begin
                    r[11:8] = v[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_sat(input logic [15:0] v);
        logic [15:0] r;
        r[3:0]   = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
        r[7:4]   = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
        r[11:8]  = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
        r[15:12] = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
        return r;
    endfunction

    // speed_up is registered so a rate change takes effect one cycle later;
    // the >= compare lets an over-limit prescaler wrap immediately.
    assign limit     = speed_q ? LIMIT_FAST : LIMIT_SLOW;
    assign tick      = (state_q == ST_RUN) && (presc_q >= limit);
    assign count_dec = bcd_dec(count_q);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        count_d = count_q;
        lap_d   = lap_q;

        if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + DIV_W'(1);
        end

        if (clear_i) begin
            state_d = ST_IDLE;
            count_d = '0;
            presc_d = '0;
            lap_d   = 1'b0;
        end else if (load_i && (state_q != ST_RUN)) begin
            count_d = bcd_sat(load_bcd_i);
            if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end else begin
            if (tick) begin
                if (!mode_q) begin
                    count_d = bcd_inc(count_q);
                end else if (count_q == 16'h0000) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = count_dec;
                    if (count_dec == 16'h0000) begin
                        state_d = ST_DONE;
                    end
                end
            end
            // A start_stop in the same cycle as a tick still counts, then pauses.
            if (start_stop_i) begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = ST_RUN;
                        mode_d  = mode_i;
                        presc_d = '0;
                    end
                    ST_RUN:   state_d = ST_PAUSE;
                    ST_PAUSE: state_d = ST_RUN;
                    default:  state_d = state_q;
                endcase
            end
        end

        if (!clear_i && lap_i && ((state_q == ST_RUN) || (state_q == ST_PAUSE))) begin
            lap_d = ~lap_q;
        end
        if (state_d == ST_DONE) begin
            lap_d = 1'b0;
        end

        // Freeze holds the value captured on the edge the lap toggled on.
        disp_d = (lap_d && lap_q) ? disp_q : count_d;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            speed_q <= 1'b0;
            presc_q <= '0;
            count_q <= '0;
            disp_q  <= '0;
            lap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            speed_q <= speed_up_i;
            presc_q <= presc_d;
            count_q <= count_d;
            disp_q  <= disp_d;
            lap_q   <= lap_d;
        end
    end

    assign digit0_o     = disp_q[3:0];
    assign digit1_o     = disp_q[7:4];
    assign digit2_o     = disp_q[11:8];
    assign digit3_o     = disp_q[15:12];
    assign running_o    = (state_q == ST_RUN);
    assign done_o       = (state_q == ST_DONE);
    assign lap_active_o = lap_q;
    assign tick_o       = tick;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed bench for stopwatch_timer: a table of operations with expected
// display/flag values, followed by hand-written multi-cycle corner cases.
module tb_stopwatch_timer;

    localparam int TD = 10;
    localparam int FF = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        speed_up, start_stop, clear, lap, mode, load;
    logic [15:0] load_bcd;
    logic [3:0]  digit0, digit1, digit2, digit3;
    logic        running, lap_active, done, tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_timer #(.TICK_DIV(TD), .FAST_FACTOR(FF), .DIV_W(8)) dut (
        .clk_i(clk), .reset_i(reset), .speed_up_i(speed_up), .start_stop_i(start_stop),
        .clear_i(clear), .lap_i(lap), .mode_i(mode), .load_i(load), .load_bcd_i(load_bcd),
        .digit0_o(digit0), .digit1_o(digit1), .digit2_o(digit2), .digit3_o(digit3),
        .running_o(running), .lap_active_o(lap_active), .done_o(done), .tick_o(tick)
    );

    typedef enum int {OP_NOP, OP_START, OP_CLEAR, OP_LAP, OP_LOAD, OP_MODE, OP_TICKS, OP_WAIT} op_e;

    typedef struct {
        op_e         op;
        int          arg;
        logic [15:0] exp_dig;
        logic        exp_run;
        logic        exp_lap;
        logic        exp_done;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(op_e op, int arg, logic [15:0] d, logic r, logic l, logic dn, string nm);
        vec_t v;
        v.op = op; v.arg = arg; v.exp_dig = d; v.exp_run = r; v.exp_lap = l; v.exp_done = dn; v.name = nm;
        vecs.push_back(v);
    endfunction

    task automatic check_state(string nm, logic [15:0] ed, logic er, logic el, logic edn);
        logic [15:0] got;
        got = {digit3, digit2, digit1, digit0};
        checks++;
        if (got !== ed || running !== er || lap_active !== el || done !== edn) begin
            errors++;
            $display("FAIL %s: got digits %h run %b lap %b done %b, expected digits %h run %b lap %b done %b",
                     nm, got, running, lap_active, done, ed, er, el, edn);
        end else begin
            $display("ok   %s: digits %h run %b lap %b done %b", nm, got, running, lap_active, done);
        end
    endtask

    task automatic check_int(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end else begin
            $display("ok   %s: %0d", nm, got);
        end
    endtask

    task automatic timeout_fail(string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for tick", nm);
    endtask

    // All stimulus is applied at a falling edge; each pulse spans exactly one rising edge.
    task automatic pulse(op_e op);
        case (op)
            OP_START: start_stop = 1'b1;
            OP_CLEAR: clear      = 1'b1;
            OP_LAP:   lap        = 1'b1;
            OP_LOAD:  load       = 1'b1;
            default:  ;
        endcase
        @(negedge clk);
        start_stop = 1'b0; clear = 1'b0; lap = 1'b0; load = 1'b0;
    endtask

    // Returns at the falling edge after the counting edge of the n-th tick.
    task automatic wait_ticks(int n, string nm);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 40 * n + 40) begin
            if (tick) seen++;
            if (seen < n) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (seen < n) timeout_fail(nm);
        @(negedge clk);
    endtask

    task automatic measure_gap(output int gap);
        int cyc = 0;
        while (!tick && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!tick && gap < 50);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int cyc;

        reset = 1'b1; speed_up = 1'b0; start_stop = 1'b0; clear = 1'b0;
        lap = 1'b0; mode = 1'b0; load = 1'b0; load_bcd = 16'h0000;

        add(OP_NOP,    0,       16'h0000, 0, 0, 0, "reset_state");
        add(OP_START,  0,       16'h0000, 1, 0, 0, "start_up");
        add(OP_TICKS,  10,      16'h0010, 1, 0, 0, "up_10_ticks");
        add(OP_TICKS,  50,      16'h0100, 1, 0, 0, "up_60_ticks");
        add(OP_START,  0,       16'h0100, 0, 0, 0, "pause");
        add(OP_LOAD,   'h9958,  16'h9958, 0, 0, 0, "load_in_pause");
        add(OP_START,  0,       16'h9958, 1, 0, 0, "resume");
        add(OP_TICKS,  1,       16'h9959, 1, 0, 0, "up_9959");
        add(OP_TICKS,  1,       16'h0000, 1, 0, 0, "up_wrap");
        add(OP_CLEAR,  0,       16'h0000, 0, 0, 0, "clear_run");
        add(OP_MODE,   1,       16'h0000, 0, 0, 0, "mode_down");
        add(OP_LOAD,   'h0003,  16'h0003, 0, 0, 0, "load_idle");
        add(OP_START,  0,       16'h0003, 1, 0, 0, "start_down");
        add(OP_TICKS,  2,       16'h0001, 1, 0, 0, "down_0001");
        add(OP_TICKS,  1,       16'h0000, 0, 0, 1, "down_done");
        add(OP_WAIT,   30,      16'h0000, 0, 0, 1, "done_holds");
        add(OP_START,  0,       16'h0000, 0, 0, 1, "done_ignores_start");
        add(OP_CLEAR,  0,       16'h0000, 0, 0, 0, "clear_done");
        add(OP_LOAD,   'h1000,  16'h1000, 0, 0, 0, "load_1000");
        add(OP_START,  0,       16'h1000, 1, 0, 0, "start_borrow");
        add(OP_TICKS,  1,       16'h0959, 1, 0, 0, "down_borrow");
        add(OP_CLEAR,  0,       16'h0000, 0, 0, 0, "clear_borrow");
        add(OP_START,  0,       16'h0000, 1, 0, 0, "down_from_zero");
        add(OP_TICKS,  1,       16'h0000, 0, 0, 1, "zero_done");
        add(OP_LOAD,   'h0042,  16'h0042, 0, 0, 0, "load_in_done");
        add(OP_LOAD,   'h7FAC,  16'h7959, 0, 0, 0, "load_saturate");
        add(OP_MODE,   0,       16'h7959, 0, 0, 0, "mode_up");
        add(OP_START,  0,       16'h7959, 1, 0, 0, "start_7959");
        add(OP_LOAD,   'h1234,  16'h7959, 1, 0, 0, "load_ignored_run");
        add(OP_TICKS,  1,       16'h8000, 1, 0, 0, "carry_8000");
        add(OP_LAP,    0,       16'h8000, 1, 1, 0, "lap_on_run");
        add(OP_START,  0,       16'h8000, 0, 1, 0, "pause_lapped");
        add(OP_LAP,    0,       16'h8000, 0, 0, 0, "lap_off_pause");
        add(OP_CLEAR,  0,       16'h0000, 0, 0, 0, "clear_lap");
        add(OP_LAP,    0,       16'h0000, 0, 0, 0, "lap_ignored_idle");
        add(OP_LOAD,   'h0005,  16'h0005, 0, 0, 0, "load_0005");
        add(OP_START,  0,       16'h0005, 1, 0, 0, "start_0005");
        add(OP_LAP,    0,       16'h0005, 1, 1, 0, "lap_freeze");
        add(OP_TICKS,  7,       16'h0005, 1, 1, 0, "frozen_7_ticks");
        add(OP_LAP,    0,       16'h0012, 1, 0, 0, "lap_release");
        add(OP_CLEAR,  0,       16'h0000, 0, 0, 0, "clear_final");

        #100;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_START, OP_CLEAR, OP_LAP: pulse(vecs[i].op);
                OP_LOAD: begin
                    load_bcd = vecs[i].arg[15:0];
                    pulse(OP_LOAD);
                end
                OP_MODE: begin
                    mode = vecs[i].arg[0];
                    @(negedge clk);
                end
                OP_TICKS: wait_ticks(vecs[i].arg, vecs[i].name);
                OP_WAIT:  repeat (vecs[i].arg) @(negedge clk);
                default:  ;
            endcase
            check_state(vecs[i].name, vecs[i].exp_dig, vecs[i].exp_run, vecs[i].exp_lap, vecs[i].exp_done);
        end

        // start_stop in the same cycle as a tick: count applied, then pause.
        pulse(OP_START);
        cyc = 0;
        while (!tick && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!tick) timeout_fail("tick_with_start");
        pulse(OP_START);
        check_state("tick_with_start", 16'h0001, 0, 0, 0);

        // clear and start_stop together: clear wins.
        clear = 1'b1;
        pulse(OP_START);
        check_state("clear_with_start", 16'h0000, 0, 0, 0);

        // Tick spacing at both rates.
        pulse(OP_START);
        measure_gap(gap);
        check_int("tick_gap_slow", gap, TD);
        speed_up = 1'b1;
        measure_gap(gap);
        measure_gap(gap);
        check_int("tick_gap_fast", gap, TD / FF);
        repeat (12) @(negedge clk);

        // Asynchronous reset between clock edges.
        #2 reset = 1'b1;
        #1;
        check_state("async_reset", 16'h0000, 0, 0, 0);
        check_int("async_reset_tick", int'(tick), 0);
        @(negedge clk);
        reset = 1'b0;
        speed_up = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
